mipi_rx_lane_aligner: RTL and testbench

- Deskews the per-lane D-PHY PPI byte streams (LANES lanes) in the rxbyteclkhs domain, ahead of the CSI-2 packet decoder.
- Measures each lane's arrival of its rxsynchs pulse and delays earlier lanes so all lanes emit their sync byte in the same cycle.
- Drives one merged, lane-aligned byte word with single valid/active/sync qualifiers, so the decoder no longer tolerates inter-lane skew itself.

---
 rtl/mipi_rx_pkg.sv | 22 ++
 rtl/mipi_rx_lane_delay.sv | 35 +++
 rtl/mipi_rx_lane_aligner.sv | 200 ++++++++++++++++++++
 tb/tb_mipi_rx_lane_aligner.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_rx_pkg.sv
// Shared types for the MIPI RX lane aligner: FSM state, sync byte,
// and the per-lane PPI word layout {data, valid, active, sync}.
package mipi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam int LANE_W = 11;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       active;
    logic       sync;
  } lane_word_t;

endpackage

// File: rtl/mipi_rx_lane_delay.sv
// One lane's delay line with a variable tap; tap k returns the lane word
// from k cycles earlier (tap 0 is the live input).
// Ports: rxbyteclkhs, reset, din (lane word), tap, dout (tapped lane word).
module mipi_rx_lane_delay
  import mipi_rx_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int TAP_WIDTH = 3
) (
  input  logic                 rxbyteclkhs,
  input  logic                 reset,
  input  logic [LANE_W-1:0]    din,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [LANE_W-1:0]    dout
);

  lane_word_t sr [DEPTH];

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  always_comb begin
    dout = din;
    for (int k = 1; k <= DEPTH; k++) begin
      if (int'(tap) == k) dout = sr[k-1];
    end
  end

endmodule

// File: rtl/mipi_rx_lane_aligner.sv
// Deskews LANES PPI byte streams on rxsynchs arrival and emits one merged,
// lane-aligned word with single valid/active/sync qualifiers.
// Ports: rxbyteclkhs, reset (sync, active-high), s_rx* per-lane inputs,
// m_rx* aligned outputs, err_skew / err_lost one-cycle error pulses.
// Optional MIPI_RX_LANE_ALIGNER_STATUS_EN adds status_skew and
// status_err_count.
module mipi_rx_lane_aligner
  import mipi_rx_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int MAX_SKEW   = 4,
  parameter int SKEW_WIDTH = 3
) (
  input  logic                  rxbyteclkhs,
  input  logic                  reset,
  input  logic [LANES*8-1:0]    s_rxdatahs,
  input  logic [LANES-1:0]      s_rxvalidhs,
  input  logic [LANES-1:0]      s_rxactivehs,
  input  logic [LANES-1:0]      s_rxsynchs,
  output logic [LANES*8-1:0]    m_rxdatahs,
  output logic                  m_rxvalidhs,
  output logic                  m_rxactivehs,
  output logic                  m_rxsynchs,
  output logic                  err_skew,
  output logic                  err_lost
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
  ,
  output logic [LANES*SKEW_WIDTH-1:0] status_skew,
  output logic [15:0]                 status_err_count
`endif
);

  localparam logic [SKEW_WIDTH-1:0] MAX_S = SKEW_WIDTH'(MAX_SKEW);

  state_t state_q, state_d;

  logic [SKEW_WIDTH-1:0] cnt_q, cnt_d, cnt_p1;
  logic [LANES-1:0]      arrived_q, arrived_d;
  logic [SKEW_WIDTH-1:0] arrival_q [LANES];
  logic [SKEW_WIDTH-1:0] arrival_d [LANES];
  logic [SKEW_WIDTH-1:0] tap_q [LANES];
  logic [SKEW_WIDTH-1:0] tap_d [LANES];

  logic go_run, skew_err, out_en;

  logic [LANES*8-1:0] tw_data;
  logic [LANES-1:0]   tw_valid, tw_active, tw_sync;
  logic all_valid, any_valid, all_active, all_sync;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] w;
    lane_word_t        lw;

    mipi_rx_lane_delay #(
      .DEPTH    (MAX_SKEW + 1),
      .TAP_WIDTH(SKEW_WIDTH)
    ) u_dly (
      .rxbyteclkhs(rxbyteclkhs),
      .reset      (reset),
      .din        ({s_rxdatahs[8*g +: 8],
                    s_rxvalidhs[g],
                    s_rxactivehs[g],
                    s_rxsynchs[g]}),
      .tap        (tap_d[g]),
      .dout       (w)
    );

    assign lw                 = w;
    assign tw_data[8*g +: 8]  = lw.data;
    assign tw_valid[g]        = lw.valid;
    assign tw_active[g]       = lw.active;
    assign tw_sync[g]         = lw.sync;
  end

  assign all_valid  = &tw_valid;
  assign any_valid  = |tw_valid;
  assign all_active = &tw_active;
  assign all_sync   = &tw_sync;

  // Arrival bookkeeping and tap computation. The taps feed the delay
  // muxes combinationally so the transition cycle already emits the
  // aligned sync bytes.
  always_comb begin
    cnt_d     = cnt_q;
    arrived_d = arrived_q;
    arrival_d = arrival_q;
    tap_d     = tap_q;
    go_run    = 1'b0;
    skew_err  = 1'b0;
    cnt_p1    = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|s_rxsynchs) begin
          arrived_d = s_rxsynchs;
          cnt_d     = '0;
          for (int i = 0; i < LANES; i++) arrival_d[i] = '0;
          if (&s_rxsynchs) begin
            go_run = 1'b1;
            for (int i = 0; i < LANES; i++) tap_d[i] = '0;
          end
        end
      end
      ALIGN: begin
        cnt_d = cnt_p1;
        for (int i = 0; i < LANES; i++) begin
          if (s_rxsynchs[i] && !arrived_q[i]) begin
            arrived_d[i] = 1'b1;
            arrival_d[i] = cnt_p1;
          end
        end
        // The last lane arrives at cnt_p1, so its tap is 0 and earlier
        // lanes wait for the difference.
        if (&arrived_d) begin
          go_run = 1'b1;
          for (int i = 0; i < LANES; i++)
            tap_d[i] = cnt_p1 - arrival_d[i];
        end else if (cnt_p1 >= MAX_S) begin
          skew_err = 1'b1;
        end
      end
      RUN: begin
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go_run)           state_d = RUN;
        else if (|s_rxsynchs) state_d = ALIGN;
      end
      ALIGN: begin
        if (go_run)        state_d = RUN;
        else if (skew_err) state_d = IDLE;
      end
      RUN: begin
        if (!all_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_en = go_run || (state_q == RUN);

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arrived_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        arrival_q[i] <= '0;
        tap_q[i]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arrived_q <= arrived_d;
      arrival_q <= arrival_d;
      tap_q     <= tap_d;
    end
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      m_rxdatahs   <= '0;
      m_rxvalidhs  <= 1'b0;
      m_rxactivehs <= 1'b0;
      m_rxsynchs   <= 1'b0;
      err_skew     <= 1'b0;
      err_lost     <= 1'b0;
    end else begin
      m_rxdatahs   <= tw_data;
      m_rxactivehs <= out_en && all_active;
      m_rxvalidhs  <= out_en && all_active && all_valid;
      m_rxsynchs   <= go_run && all_sync;
      err_skew     <= skew_err;
      err_lost     <= out_en && all_active && any_valid && !all_valid;
    end
  end

`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      status_skew      <= '0;
      status_err_count <= '0;
    end else begin
      if (go_run) begin
        for (int i = 0; i < LANES; i++)
          status_skew[i*SKEW_WIDTH +: SKEW_WIDTH] <= tap_d[i];
      end
      if ((err_skew || err_lost) && status_err_count != 16'hFFFF)
        status_err_count <= status_err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mipi_rx_lane_aligner.sv
// Scoreboard bench for mipi_rx_lane_aligner: 2-lane and 4-lane instances,
// directed bursts with hand-computed aligned outputs.
module tb_mipi_rx_lane_aligner;
  import mipi_rx_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        v, a, s, es, el;
  } exp_t;

  logic rxbyteclkhs = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic [31:0] d;
  logic [3:0]  v, a, s;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 rxbyteclkhs = ~rxbyteclkhs;
  always @(posedge rxbyteclkhs) cyc <= cyc + 1;

  logic [15:0] d2;
  logic [1:0]  v2, a2, s2;
  logic [31:0] d4;
  logic [3:0]  v4, a4, s4;
  assign d2 = sel ? 16'h0 : d[15:0];
  assign v2 = sel ? 2'b0 : v[1:0];
  assign a2 = sel ? 2'b0 : a[1:0];
  assign s2 = sel ? 2'b0 : s[1:0];
  assign d4 = sel ? d : 32'h0;
  assign v4 = sel ? v : 4'b0;
  assign a4 = sel ? a : 4'b0;
  assign s4 = sel ? s : 4'b0;

  logic [15:0] m2_d;
  logic m2_v, m2_a, m2_s, m2_es, m2_el;
  logic [31:0] m4_d;
  logic m4_v, m4_a, m4_s, m4_es, m4_el;
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
  logic [5:0]  st2_skew;
  logic [15:0] st2_cnt;
  logic [11:0] st4_skew;
  logic [15:0] st4_cnt;
`endif

  mipi_rx_lane_aligner #(.LANES(2), .MAX_SKEW(4), .SKEW_WIDTH(3)) dut2 (
    .rxbyteclkhs (rxbyteclkhs),
    .reset       (reset),
    .s_rxdatahs  (d2),
    .s_rxvalidhs (v2),
    .s_rxactivehs(a2),
    .s_rxsynchs  (s2),
    .m_rxdatahs  (m2_d),
    .m_rxvalidhs (m2_v),
    .m_rxactivehs(m2_a),
    .m_rxsynchs  (m2_s),
    .err_skew    (m2_es),
    .err_lost    (m2_el)
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    ,
    .status_skew     (st2_skew),
    .status_err_count(st2_cnt)
`endif
  );

  mipi_rx_lane_aligner #(.LANES(4), .MAX_SKEW(4), .SKEW_WIDTH(3)) dut4 (
    .rxbyteclkhs (rxbyteclkhs),
    .reset       (reset),
    .s_rxdatahs  (d4),
    .s_rxvalidhs (v4),
    .s_rxactivehs(a4),
    .s_rxsynchs  (s4),
    .m_rxdatahs  (m4_d),
    .m_rxvalidhs (m4_v),
    .m_rxactivehs(m4_a),
    .m_rxsynchs  (m4_s),
    .err_skew    (m4_es),
    .err_lost    (m4_el)
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    ,
    .status_skew     (st4_skew),
    .status_err_count(st4_cnt)
`endif
  );

  task automatic tick();
    @(posedge rxbyteclkhs);
    #1;
  endtask

  task automatic drive_idle();
    d = '0;
    v = '0;
    a = '0;
    s = '0;
  endtask

  task automatic gap(input int n);
    drive_idle();
    repeat (n) tick();
  endtask

  // Lane i sends sync at st+off[i], then payload 16*i+k, k=0..n-1.
  // drop_k drops lane 1 valid for payload k; rst_at pulses reset.
  task automatic burst(input int nl, input int o0, input int o1,
                       input int o2, input int o3, input int n,
                       input int drop_k, input int rst_at);
    int   off [4];
    int   lmax, st, k, cy;
    exp_t e;
    off[0] = o0;
    off[1] = o1;
    off[2] = o2;
    off[3] = o3;
    lmax = 0;
    for (int i = 0; i < nl; i++) if (off[i] > lmax) lmax = off[i];
    st = cyc;
    for (int j = 0; j <= n; j++) begin
      cy = st + lmax + 1 + j;
      if (rst_at >= 0 && cy > st + rst_at) break;
      e.cyc  = cy;
      e.data = '0;
      e.a    = 1'b1;
      e.s    = (j == 0);
      e.es   = 1'b0;
      e.el   = (j > 0 && j - 1 == drop_k);
      e.v    = !e.el;
      for (int i = 0; i < nl; i++)
        e.data[8*i +: 8] = (j == 0) ? SYNC_BYTE : 8'(16*i + j - 1);
      q.push_back(e);
    end
    e.cyc  = (rst_at >= 0) ? st + rst_at + 1 : st + lmax + n + 2;
    e.data = '0;
    e.v    = 1'b0;
    e.a    = 1'b0;
    e.s    = 1'b0;
    e.es   = 1'b0;
    e.el   = 1'b0;
    q.push_back(e);
    for (int t = 0; t <= lmax + n + 1; t++) begin
      drive_idle();
      reset = (t == rst_at);
      for (int i = 0; i < nl; i++) begin
        k = t - off[i];
        if (k == 0) begin
          d[8*i +: 8] = SYNC_BYTE;
          v[i] = 1'b1;
          a[i] = 1'b1;
          s[i] = 1'b1;
        end else if (k >= 1 && k <= n) begin
          d[8*i +: 8] = 8'(16*i + k - 1);
          v[i] = !(i == 1 && k - 1 == drop_k);
          a[i] = 1'b1;
        end
      end
      tick();
    end
    drive_idle();
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   st;
    drive_idle();
    repeat (3) tick();
    checks++;
    if ({m2_d, m2_v, m2_a, m2_s, m2_es, m2_el} !== 21'h0) begin
      errors++;
      $display("FAIL reset2 got=%h want=0",
               {m2_d, m2_v, m2_a, m2_s, m2_es, m2_el});
    end
    checks++;
    if ({m4_d, m4_v, m4_a, m4_s, m4_es, m4_el} !== 37'h0) begin
      errors++;
      $display("FAIL reset4 got=%h want=0",
               {m4_d, m4_v, m4_a, m4_s, m4_es, m4_el});
    end
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    checks++;
    if (st2_cnt !== 16'd0 || st2_skew !== 6'd0) begin
      errors++;
      $display("FAIL reset_status cnt=%h skew=%h want=0", st2_cnt, st2_skew);
    end
`endif
    reset = 1'b0;

    fork
      begin : mon
        logic        pa, ov, oa, os, oes, oel;
        logic [31:0] od;
        exp_t        x;
        pa = 1'b0;
        forever begin
          @(negedge rxbyteclkhs);
          if (sel) begin
            od = m4_d; ov = m4_v; oa = m4_a;
            os = m4_s; oes = m4_es; oel = m4_el;
          end else begin
            od = {16'h0, m2_d}; ov = m2_v; oa = m2_a;
            os = m2_s; oes = m2_es; oel = m2_el;
          end
          if (ov || os || oes || oel || (oa != pa)) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL unexpected cyc=%0d v%b a%b s%b es%b el%b d=%h",
                       cyc, ov, oa, os, oes, oel, od);
            end else begin
              x = q.pop_front();
              if (cyc != x.cyc || ov !== x.v || oa !== x.a || os !== x.s ||
                  oes !== x.es || oel !== x.el || (x.v && od !== x.data)) begin
                errors++;
                $display("FAIL out got cyc=%0d v%b a%b s%b es%b el%b d=%h want cyc=%0d v%b a%b s%b es%b el%b d=%h",
                         cyc, ov, oa, os, oes, oel, od,
                         x.cyc, x.v, x.a, x.s, x.es, x.el, x.data);
              end
            end
          end
          pa = oa;
        end
      end
    join_none

    gap(5);
    burst(2, 0, 0, 0, 0, 16, -1, -1);
    gap(5);
    burst(2, 0, 1, 0, 0, 8, -1, -1);
    gap(5);
    burst(2, 0, 4, 0, 0, 6, -1, -1);
    gap(5);

    st = cyc;
    e.cyc = st + 5; e.data = '0;
    e.v = 0; e.a = 0; e.s = 0; e.es = 1; e.el = 0;
    q.push_back(e);
    for (int t = 0; t < 9; t++) begin
      drive_idle();
      d[7:0] = (t == 0) ? SYNC_BYTE : 8'(t - 1);
      v[0] = 1'b1;
      a[0] = 1'b1;
      s[0] = (t == 0);
      tick();
    end
    gap(5);

    burst(2, 0, 0, 0, 0, 10, -1, 6);
    gap(5);
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    checks++;
    if (st2_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_after_reset got=%0d want=0", st2_cnt);
    end
`endif
    burst(2, 1, 0, 0, 0, 8, 3, -1);
    gap(5);
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    checks++;
    if (st2_cnt !== 16'd1) begin
      errors++;
      $display("FAIL cnt_after_lost got=%0d want=1", st2_cnt);
    end
`endif

    sel = 1'b1;
    gap(3);
    burst(4, 0, 3, 1, 2, 8, -1, -1);
    gap(5);
`ifdef MIPI_RX_LANE_ALIGNER_STATUS_EN
    checks++;
    if (st4_skew !== 12'h283) begin
      errors++;
      $display("FAIL status_skew got=%h want=283", st4_skew);
    end
`endif
    burst(4, 2, 0, 1, 0, 6, -1, -1);
    gap(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d pending want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
